hex_display_scanner: RTL and testbench
======================================

// Module: hex_display_scanner
// PURPOSE
//   Time-multiplexed scan controller for a multi-digit 7-segment display.
//   Latches a packed hex word, cycles one-hot digit selects at a fixed slot rate, and drives
//   the per-digit nibble, dark and lamp-test controls into the downstream hex-to-7-segment decoder.
//   Adds an anti-ghosting gap per slot, leading-zero blanking, and tear-free updates at frame boundaries.
// PARAMETERS
//   NUM_DIGITS  4     digits scanned; >=2. Digit 0 = least significant nibble.
//   CLK_DIV     1000  clk cycles per digit slot; >=2.
//   GAP_CYCLES  16    cycles at slot start with darkN=0 (anti-ghost); 0 <= GAP_CYCLES < CLK_DIV.
// PORTS
//   clk           in   1             system clock, rising edge
//   rst_n         in   1             asynchronous reset, active low
//   enable        in   1             1 = scan running, 0 = display off
//   data_in       in   4*NUM_DIGITS  packed hex value; nibble i -> digit i
//   load          in   1             1-cycle strobe; capture data_in
//   lz_blank      in   1             1 = suppress leading zeros
//   lamp_test_in  in   1             1 = all segments lit on every digit
//   hexin         out  4             nibble of current digit to decoder
//   darkN         out  1             0 = decoder output blank
//   LampTest      out  1             decoder lamp-test
//   digit_sel     out  NUM_DIGITS    one-hot common-drive select, 0 when idle
//   frame_done    out  1             1-cycle pulse in last cycle of last slot
// BEHAVIOUR
//   - Reset (async, rst_n=0): all outputs 0; slot/digit counters 0; disp_reg, pend_reg 0; pend_vld 0; state IDLE.
//   - All outputs registered. States: IDLE, SCAN.
//   - IDLE: digit_sel=0, darkN=0, LampTest=0, hexin=0, frame_done=0. enable=1 sampled -> SCAN.
//   - SCAN: first cycle after entry: digit 0, slot count 0. Each slot = CLK_DIV cycles, digit_sel one-hot
//     for the whole slot; darkN forced 0 for slot cycles 0..GAP_CYCLES-1. Order 0,1,..,NUM_DIGITS-1, wrap to 0.
//   - frame_done=1 exactly in final cycle of digit NUM_DIGITS-1 slot.
//   - enable=0 sampled in SCAN -> IDLE next cycle; counters cleared; re-enable restarts at digit 0, count 0.
//   - Load/tear-free: load=1 -> pend_reg<=data_in, pend_vld<=1. At frame boundary (wrap to digit 0) with
//     pend_vld: disp_reg<=pend_reg, pend_vld<=0; new frame shows new data. load repeated before boundary:
//     last value wins. load on boundary cycle: existing pending commits, new value becomes pending.
//     In IDLE, a pending value commits on the next cycle.
//   - Per-digit outputs outside the gap: hexin=disp_reg[4i+3:4i].
//     blanked(i) = lz_blank & (i!=0) & all nibbles NUM_DIGITS-1..i of disp_reg are zero.
//     lamp_test_in=1: LampTest=1, darkN=1 (blank ignored). Else LampTest=0, darkN=!blanked(i).
//     During gap: darkN=0, LampTest=0; hexin and digit_sel still show current digit.
//   - lz_blank and lamp_test_in are sampled every cycle; no frame-boundary sync.
//   - Digit 0 is never leading-zero blanked; all-zero value shows a single "0".
// TESTING  (NUM_DIGITS=4, CLK_DIV=8, GAP_CYCLES=2)
//   1. rst_n=0 mid-slot -> all outputs 0 immediately without clock; release + enable -> digit_sel=0001, count 0.
//   2. load 16'h12AF then enable -> slots 0001/F, 0010/A, 0100/2, 1000/1; darkN 0,0,1x6 per slot; frame_done period 32.
//   3. Running on 16'h12AF, load 16'h5555 in cycle 10 of frame -> rest of frame shows 12AF; next frame shows 5555.
//   4. lz_blank=1, data 16'h0030 -> digits 3,2 darkN=0 whole slot; digit1 hexin=3, digit0 hexin=0 lit; 16'h0000 -> only digit0 lit.
//   5. lamp_test_in=1 with lz_blank=1, data 16'h0000 -> all 4 digits LampTest=1, darkN=1 except gap cycles.
//   6. enable=0 in cycle 5 of digit 2 -> next cycle digit_sel=0, darkN=0; enable=1 -> restart at digit 0, cycle 0.

Source files
------------

// File: rtl/hex_display_scanner.sv
// Scan controller for a multiplexed 7-segment display: walks a one-hot digit select,
// presents each digit's nibble with gap, leading-zero and lamp-test control, and swaps data only at frame ends.
module hex_display_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 1000,
  parameter int GAP_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic                    load,
  input  logic                    lz_blank,
  input  logic                    lamp_test_in,
  output logic [3:0]              hexin,
  output logic                    darkN,
  output logic                    LampTest,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int DW = $clog2(NUM_DIGITS);
  localparam int DATA_W = 4 * NUM_DIGITS;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SCAN = 1'b1;

  localparam logic [CW-1:0] LAST_CNT = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(GAP_CYCLES);
  localparam logic [DW-1:0] LAST_DIG = DW'(NUM_DIGITS - 1);

  logic [0:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DW-1:0]         dig_q, dig_d;
  logic [DATA_W-1:0]     disp_q, disp_d;
  logic [DATA_W-1:0]     pend_q, pend_d;
  logic                  pend_vld_q, pend_vld_d;

  logic [3:0]            hexin_q, hexin_d;
  logic                  dark_n_q, dark_n_d;
  logic                  lamp_test_q, lamp_test_d;
  logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;
  logic                  frame_done_q, frame_done_d;

  logic wrap;
  logic commit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    wrap    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_SCAN;
          cnt_d   = '0;
          dig_d   = '0;
        end
      end
      default: begin
        if (!enable) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          dig_d   = '0;
        end else if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (dig_q == LAST_DIG) begin
            dig_d = '0;
            wrap  = 1'b1;
          end else begin
            dig_d = dig_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // Pending data reaches the display only at a frame wrap (or at once while idle),
  // so a frame never mixes old and new digits. A load in the commit cycle re-arms pending.
  assign commit     = pend_vld_q & (wrap | (state_q == S_IDLE));
  assign disp_d     = commit ? pend_q : disp_q;
  assign pend_d     = load ? data_in : pend_q;
  assign pend_vld_d = load | (pend_vld_q & ~commit);

  logic [3:0]            nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:1] nib_zero;
  logic [NUM_DIGITS-1:1] lead_zero;
  logic [NUM_DIGITS-1:0] blank_vec;

  assign nib[0]       = disp_d[3:0];
  assign blank_vec[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_DIGITS; gi++) begin : g_digit
      assign nib[gi]      = disp_d[4*gi +: 4];
      assign nib_zero[gi] = (nib[gi] == 4'h0);
      if (gi == NUM_DIGITS - 1) begin : g_top
        assign lead_zero[gi] = nib_zero[gi];
      end else begin : g_low
        assign lead_zero[gi] = nib_zero[gi] & lead_zero[gi+1];
      end
      assign blank_vec[gi] = lz_blank & lead_zero[gi];
    end
  endgenerate

  logic scan_d;
  logic in_gap;
  logic lit;

  // Outputs are derived from next-state values so the registered pins line up with the counters.
  assign scan_d       = (state_d == S_SCAN);
  assign in_gap       = (cnt_d < GAP_END);
  assign lit          = scan_d & ~in_gap;
  assign digit_sel_d  = scan_d ? (NUM_DIGITS'(1) << dig_d) : '0;
  assign hexin_d      = scan_d ? nib[dig_d] : 4'h0;
  assign lamp_test_d  = lit & lamp_test_in;
  assign dark_n_d     = lit & (lamp_test_in | ~blank_vec[dig_d]);
  assign frame_done_d = scan_d & (dig_d == LAST_DIG) & (cnt_d == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      dig_q        <= '0;
      disp_q       <= '0;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      hexin_q      <= 4'h0;
      dark_n_q     <= 1'b0;
      lamp_test_q  <= 1'b0;
      digit_sel_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dig_q        <= dig_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      hexin_q      <= hexin_d;
      dark_n_q     <= dark_n_d;
      lamp_test_q  <= lamp_test_d;
      digit_sel_q  <= digit_sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign hexin      = hexin_q;
  assign darkN      = dark_n_q;
  assign LampTest   = lamp_test_q;
  assign digit_sel  = digit_sel_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner (4 digits, 8-cycle slots, 2-cycle gap): per-cycle expected
// outputs are queued as stimulus is applied and compared on the falling edge.
module tb_hex_display_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] data_in = 16'h0;
  logic        load = 1'b0;
  logic        lz_blank = 1'b0;
  logic        lamp_test_in = 1'b0;
  logic [3:0]  hexin;
  logic        darkN;
  logic        LampTest;
  logic [3:0]  digit_sel;
  logic        frame_done;

  hex_display_scanner #(.NUM_DIGITS(4), .CLK_DIV(8), .GAP_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .data_in(data_in), .load(load),
    .lz_blank(lz_blank), .lamp_test_in(lamp_test_in), .hexin(hexin), .darkN(darkN),
    .LampTest(LampTest), .digit_sel(digit_sel), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] sel;
    logic [3:0] hex;
    logic       dark;
    logic       lt;
    logic       fd;
  } exp_t;

  typedef struct {
    logic [15:0] data;
    logic        lz;
    logic        lamp;
    logic [3:0]  lit;
    string       tag;
  } vec_t;

  localparam exp_t IDLE_EXP = '{sel: 4'b0, hex: 4'h0, dark: 1'b0, lt: 1'b0, fd: 1'b0};

  exp_t  sb[$];
  string tag = "reset";
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic check(input exp_t e);
    n_cmp++;
    if ({digit_sel, hexin, darkN, LampTest, frame_done} !== e) begin
      n_bad++;
      $display("FAIL %s @%0t: got sel=%b hex=%h darkN=%b lt=%b fd=%b, expected sel=%b hex=%h darkN=%b lt=%b fd=%b",
               tag, $time, digit_sel, hexin, darkN, LampTest, frame_done, e.sel, e.hex, e.dark, e.lt, e.fd);
    end
  endtask

  task automatic drain(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s: scoreboard empty, got sel=%b, required an expectation", tag, digit_sel);
      end else begin
        e = sb.pop_front();
        check(e);
      end
    end
  endtask

  // Queue the first n cycles of a frame; lit[d] says whether digit d is shown past the gap.
  task automatic push_frame(input logic [15:0] data, input logic lamp, input logic [3:0] lit, input int n);
    exp_t e;
    int   d;
    int   c;
    for (int k = 0; k < n; k++) begin
      d = k / 8;
      c = k % 8;
      e.sel  = 4'b0001 << d;
      e.hex  = data[4*d +: 4];
      e.dark = (c >= 2) && (lamp || lit[d]);
      e.lt   = (c >= 2) && lamp;
      e.fd   = (d == 3) && (c == 7);
      sb.push_back(e);
    end
  endtask

  task automatic go_idle_load(input logic [15:0] data);
    enable = 1'b0;
    sb.push_back(IDLE_EXP);
    drain(1);
    load    = 1'b1;
    data_in = data;
    sb.push_back(IDLE_EXP);
    drain(1);
    load = 1'b0;
    sb.push_back(IDLE_EXP);
    drain(1);
  endtask

  vec_t vt[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{data: 16'h0030, lz: 1'b1, lamp: 1'b0, lit: 4'b0011, tag: "lzb_0030"};
    vt[1] = '{data: 16'h0000, lz: 1'b1, lamp: 1'b0, lit: 4'b0001, tag: "lzb_0000"};
    vt[2] = '{data: 16'h0000, lz: 1'b0, lamp: 1'b0, lit: 4'b1111, tag: "nolz_0000"};
    vt[3] = '{data: 16'h0A00, lz: 1'b1, lamp: 1'b0, lit: 4'b0111, tag: "lzb_0A00"};
    vt[4] = '{data: 16'h1000, lz: 1'b1, lamp: 1'b0, lit: 4'b1111, tag: "lzb_1000"};
    vt[5] = '{data: 16'h0000, lz: 1'b1, lamp: 1'b1, lit: 4'b0001, tag: "lamp_0000"};

    #3;
    tag = "reset_state";
    check(IDLE_EXP);
    @(negedge clk);
    rst_n = 1'b1;
    tag = "idle_after_reset";
    sb.push_back(IDLE_EXP);
    sb.push_back(IDLE_EXP);
    drain(2);

    // Two full frames of 12AF back to back: slot order, gap and a 32-cycle frame_done period.
    tag = "scan_12AF";
    go_idle_load(16'h12AF);
    enable = 1'b1;
    push_frame(16'h12AF, 1'b0, 4'b1111, 32);
    push_frame(16'h12AF, 1'b0, 4'b1111, 32);
    drain(64);

    tag = "tear_free";
    push_frame(16'h12AF, 1'b0, 4'b1111, 32);
    push_frame(16'h5555, 1'b0, 4'b1111, 32);
    drain(11);
    load    = 1'b1;
    data_in = 16'h5555;
    drain(1);
    load = 1'b0;
    drain(52);

    for (int i = 0; i < 6; i++) begin
      tag = vt[i].tag;
      go_idle_load(vt[i].data);
      lz_blank     = vt[i].lz;
      lamp_test_in = vt[i].lamp;
      enable       = 1'b1;
      push_frame(vt[i].data, vt[i].lamp, vt[i].lit, 32);
      drain(32);
    end

    // Disable in cycle 5 of digit 2, then restart from digit 0 cycle 0.
    tag = "disable_mid";
    lz_blank     = 1'b0;
    lamp_test_in = 1'b0;
    go_idle_load(16'h12AF);
    enable = 1'b1;
    push_frame(16'h12AF, 1'b0, 4'b1111, 22);
    drain(22);
    enable = 1'b0;
    sb.push_back(IDLE_EXP);
    sb.push_back(IDLE_EXP);
    drain(2);
    tag = "restart";
    enable = 1'b1;
    push_frame(16'h12AF, 1'b0, 4'b1111, 32);
    drain(32);

    // Asynchronous reset between clock edges mid-slot.
    tag = "async_reset";
    push_frame(16'h12AF, 1'b0, 4'b1111, 13);
    drain(13);
    #2;
    rst_n = 1'b0;
    #1;
    check(IDLE_EXP);
    @(negedge clk);
    check(IDLE_EXP);
    rst_n = 1'b1;
    tag = "after_reset_scan";
    push_frame(16'h0000, 1'b0, 4'b1111, 32);
    drain(32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
